sipo_deserializer: RTL and testbench

Serial-in, parallel-out capture stage fed by the team's `DFF` storage cells. It samples a gated serial bit stream `D`, assembles `WIDTH`-bit words, and presents each word on a held parallel output with a valid/acknowledge handshake. The shift register and the output holding register form a double buffer, so one word can be consumed downstream while the next is still being assembled.

---
 rtl/sipo_deserializer.sv | 77 +++++++
 tb/tb_sipo_deserializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer: strobed bits are assembled into WIDTH-bit words
// and handed to a held output register with a valid/acknowledge handshake.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             D,
  input  logic             E,
  input  logic             A,
  output logic [WIDTH-1:0] P,
  output logic             V,
  output logic             B,
  output logic             O
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_c;
  logic [WIDTH-1:0] r_p;
  logic             r_v;
  logic             r_o;

  logic [WIDTH-1:0] w_s_shifted;
  logic [CW-1:0]    w_c_next;
  logic             w_last_bit;
  logic             w_complete;

  // Bit order only changes which end of the shift register the new bit enters.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_s_shifted = {r_s[WIDTH-2:0], D};
    end else begin : g_lsb_first
      assign w_s_shifted = {D, r_s[WIDTH-1:1]};
    end
  endgenerate

  assign w_last_bit = (r_c == LAST_BIT);
  assign w_c_next   = w_last_bit ? '0 : r_c + CW'(1);
  assign w_complete = E && w_last_bit;

  always_ff @(posedge clk) begin
    if (R) begin
      r_s <= '0;
      r_c <= '0;
      r_p <= '0;
      r_v <= 1'b0;
      r_o <= 1'b0;
    end else begin
      r_o <= 1'b0;
      if (E) begin
        r_s <= w_s_shifted;
        r_c <= w_c_next;
      end
      // A completing word replaces the held one only if the slot is empty or being consumed now.
      if (w_complete) begin
        if (!r_v || A) begin
          r_p <= w_s_shifted;
          r_v <= 1'b1;
        end else begin
          r_o <= 1'b1;
        end
      end else if (r_v && A) begin
        r_v <= 1'b0;
      end
    end
  end

  assign P = r_p;
  assign V = r_v;
  assign O = r_o;
  assign B = (r_c != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer: one MSB-first and one LSB-first instance.
module tb_sipo_deserializer;

  logic       clk;
  logic       r_m, d_m, e_m, a_m;
  logic [7:0] p_m;
  logic       v_m, b_m, o_m;
  logic       r_l, d_l, e_l, a_l;
  logic [7:0] p_l;
  logic       v_l, b_l, o_l;

  int n_vec;
  int n_err;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .R(r_m), .D(d_m), .E(e_m), .A(a_m),
    .P(p_m), .V(v_m), .B(b_m), .O(o_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .R(r_l), .D(d_l), .E(e_l), .A(a_l),
    .P(p_l), .V(v_l), .B(b_l), .O(o_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word MSB-first on the MSB instance; ack_last raises A on the final bit edge.
  task automatic send_word_msb(input logic [7:0] w, input bit ack_last, input int max_gap,
                               input bit chk_busy);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (chk_busy) begin
          n_vec++;
          if (b_m !== (i != 0)) begin
            n_err++;
            $display("FAIL busy_gap bit%0d: B=%b expected %b", i, b_m, (i != 0));
          end
        end
      end
      d_m = w[7-i];
      e_m = 1'b1;
      a_m = (i == 7) ? ack_last : 1'b0;
      tick();
      e_m = 1'b0;
      a_m = 1'b0;
      if (chk_busy && i < 7) begin
        n_vec++;
        if (b_m !== 1'b1) begin
          n_err++;
          $display("FAIL busy_bit%0d: B=%b expected 1", i, b_m);
        end
      end
    end
    $display("word 0x%02h sent msb-first: P=0x%02h V=%b B=%b O=%b", w, p_m, v_m, b_m, o_m);
  endtask

  task automatic send_word_lsb(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      d_l = w[i];
      e_l = 1'b1;
      tick();
      e_l = 1'b0;
    end
    $display("word 0x%02h sent lsb-first: P=0x%02h V=%b B=%b O=%b", w, p_l, v_l, b_l, o_l);
  endtask

  task automatic ack_msb();
    a_m = 1'b1;
    tick();
    a_m = 1'b0;
  endtask

  task automatic test_reset();
    r_m = 1'b1; e_m = 1'b1; d_m = 1'b1; a_m = 1'b0;
    r_l = 1'b1; e_l = 1'b1; d_l = 1'b1; a_l = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if ({p_m, v_m, b_m, o_m} !== 11'h000) begin
        n_err++;
        $display("FAIL reset_msb cyc%0d: P=%h V=%b B=%b O=%b expected 00 0 0 0", k, p_m, v_m, b_m, o_m);
      end
      n_vec++;
      if ({p_l, v_l, b_l, o_l} !== 11'h000) begin
        n_err++;
        $display("FAIL reset_lsb cyc%0d: P=%h V=%b B=%b O=%b expected 00 0 0 0", k, p_l, v_l, b_l, o_l);
      end
    end
    r_m = 1'b0; e_m = 1'b0; d_m = 1'b0;
    r_l = 1'b0; e_l = 1'b0; d_l = 1'b0;
    tick();
    n_vec++;
    if (b_m !== 1'b0) begin
      n_err++;
      $display("FAIL reset_count: B=%b expected 0", b_m);
    end
    $display("reset applied for 2 cycles");
  endtask

  task automatic test_back_to_back();
    send_word_msb(8'hA5, 1'b0, 0, 1'b1);
    n_vec++;
    if (p_m !== 8'hA5 || v_m !== 1'b1 || b_m !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_word: P=%h V=%b B=%b expected a5 1 0", p_m, v_m, b_m);
    end
    ack_msb();
    n_vec++;
    if (v_m !== 1'b0 || p_m !== 8'hA5) begin
      n_err++;
      $display("FAIL b2b_ack: V=%b P=%h expected 0 a5", v_m, p_m);
    end
    // A with V low must not change anything.
    ack_msb();
    n_vec++;
    if (v_m !== 1'b0 || p_m !== 8'hA5 || o_m !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack: V=%b P=%h O=%b expected 0 a5 0", v_m, p_m, o_m);
    end
  endtask

  task automatic test_gapped();
    send_word_msb(8'h3C, 1'b0, 3, 1'b1);
    n_vec++;
    if (p_m !== 8'h3C || v_m !== 1'b1 || b_m !== 1'b0) begin
      n_err++;
      $display("FAIL gapped_word: P=%h V=%b B=%b expected 3c 1 0", p_m, v_m, b_m);
    end
    ack_msb();
    n_vec++;
    if (v_m !== 1'b0) begin
      n_err++;
      $display("FAIL gapped_ack: V=%b expected 0", v_m);
    end
  endtask

  task automatic test_overrun();
    send_word_msb(8'h11, 1'b0, 0, 1'b0);
    n_vec++;
    if (p_m !== 8'h11 || v_m !== 1'b1 || o_m !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_first: P=%h V=%b O=%b expected 11 1 0", p_m, v_m, o_m);
    end
    send_word_msb(8'h22, 1'b0, 0, 1'b0);
    n_vec++;
    if (o_m !== 1'b1 || p_m !== 8'h11 || v_m !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_pulse: O=%b P=%h V=%b expected 1 11 1", o_m, p_m, v_m);
    end
    tick();
    n_vec++;
    if (o_m !== 1'b0 || p_m !== 8'h11 || v_m !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_after: O=%b P=%h V=%b expected 0 11 1", o_m, p_m, v_m);
    end
  endtask

  task automatic test_simultaneous();
    // V is still high holding 0x11; ack lands on the 0x22 completion edge.
    send_word_msb(8'h22, 1'b1, 0, 1'b0);
    n_vec++;
    if (p_m !== 8'h22 || v_m !== 1'b1 || o_m !== 1'b0) begin
      n_err++;
      $display("FAIL simul: P=%h V=%b O=%b expected 22 1 0", p_m, v_m, o_m);
    end
    ack_msb();
    n_vec++;
    if (v_m !== 1'b0 || p_m !== 8'h22) begin
      n_err++;
      $display("FAIL simul_ack: V=%b P=%h expected 0 22", v_m, p_m);
    end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++) begin
      d_m = 1'b1; e_m = 1'b1;
      tick();
      e_m = 1'b0;
    end
    n_vec++;
    if (b_m !== 1'b1) begin
      n_err++;
      $display("FAIL mid_busy: B=%b expected 1", b_m);
    end
    r_m = 1'b1;
    tick();
    r_m = 1'b0;
    n_vec++;
    if (b_m !== 1'b0 || p_m !== 8'h00 || v_m !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: B=%b P=%h V=%b expected 0 00 0", b_m, p_m, v_m);
    end
    send_word_msb(8'hF0, 1'b0, 0, 1'b1);
    n_vec++;
    if (p_m !== 8'hF0 || v_m !== 1'b1) begin
      n_err++;
      $display("FAIL mid_word: P=%h V=%b expected f0 1", p_m, v_m);
    end
    // Reset with a word pending drops it.
    r_m = 1'b1;
    tick();
    r_m = 1'b0;
    n_vec++;
    if (v_m !== 1'b0 || p_m !== 8'h00) begin
      n_err++;
      $display("FAIL pend_reset: V=%b P=%h expected 0 00", v_m, p_m);
    end
  endtask

  task automatic test_lsb_first();
    send_word_lsb(8'hA5);
    n_vec++;
    if (p_l !== 8'hA5 || v_l !== 1'b1 || b_l !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_a5: P=%h V=%b B=%b expected a5 1 0", p_l, v_l, b_l);
    end
    a_l = 1'b1;
    tick();
    a_l = 1'b0;
    send_word_lsb(8'h01);
    n_vec++;
    if (p_l !== 8'h01 || v_l !== 1'b1) begin
      n_err++;
      $display("FAIL lsb_01: P=%h V=%b expected 01 1", p_l, v_l);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    r_m = 1'b0; d_m = 1'b0; e_m = 1'b0; a_m = 1'b0;
    r_l = 1'b0; d_l = 1'b0; e_l = 1'b0; a_l = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_overrun();
    test_simultaneous();
    test_reset_midword();
    test_lsb_first();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
